// File: rtl/csr_arbiter_if.sv
// Requester/response/CSR bundle for csr_arbiter. The slave modport is the
// arbiter's view; the master modport is the requesters' and CSR file's view.
interface csr_arbiter_if #(
  parameter int AW = 8,
  parameter int DW = 32
);
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [1:0]      req_lock;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic [1:0]      rsp_ready;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            csr_wen;
  logic            csr_ren;
  logic [AW-1:0]   csr_addr;
  logic [DW-1:0]   csr_wdata;
  logic [DW-1:0]   csr_rdata;

  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata, rsp_ready, csr_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, csr_wen, csr_ren, csr_addr, csr_wdata
  );

  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata, rsp_ready, csr_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, csr_wen, csr_ren, csr_addr, csr_wdata
  );
endinterface

// File: rtl/csr_arbiter.sv
// Two-requester CSR arbiter: round-robin grant with optional ownership lock,
// zero-latency request accept and a registered single-cycle response.
module csr_arbiter #(
  parameter int                      CSR_ADDR_WIDTH = 8,
  parameter int                      CSR_DATA_WIDTH = 32,
  parameter logic [CSR_ADDR_WIDTH-1:0] CSR_LIMIT    = 8'h80,
  parameter int                      LOCK_TIMEOUT   = 64
) (
  input  logic          clk,
  input  logic          rst,
  csr_arbiter_if.slave  bus,
  output logic          busy,
  output logic          owner,
  output logic          locked,
  output logic          lock_timeout
);
  localparam int AW    = CSR_ADDR_WIDTH;
  localparam int DW    = CSR_DATA_WIDTH;
  localparam int CNT_W = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {IDLE, RESP} state_e;

  state_e           state_q;
  logic             prio_q;
  logic             owner_q;
  logic             locked_q;
  logic             lock_timeout_q;
  logic             rsp_err_q;
  logic [CNT_W-1:0] idle_cnt_q;
  logic [DW-1:0]    rsp_rdata_q;

  logic [AW-1:0] addr_arr  [2];
  logic [DW-1:0] wdata_arr [2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_unpack
      assign addr_arr[gi]  = bus.req_addr[gi*AW +: AW];
      assign wdata_arr[gi] = bus.req_wdata[gi*DW +: DW];
    end
  endgenerate

  logic [1:0]    eligible;
  logic          grant;
  logic          winner;
  logic          in_range;
  logic          win_we;
  logic          win_lock;
  logic [AW-1:0] win_addr;
  logic [DW-1:0] win_wdata;

  // While locked only the owner may compete; nothing is granted in RESP or reset.
  always_comb begin
    eligible = 2'b00;
    if (state_q == IDLE && !rst)
      eligible = locked_q ? (bus.req_valid & (owner_q ? 2'b10 : 2'b01)) : bus.req_valid;
    grant     = |eligible;
    winner    = (&eligible) ? prio_q : eligible[1];
    win_addr  = addr_arr[winner];
    win_wdata = wdata_arr[winner];
    win_we    = bus.req_we[winner];
    win_lock  = bus.req_lock[winner];
    in_range  = win_addr < CSR_LIMIT;
  end

  assign bus.req_ready = grant ? (winner ? 2'b10 : 2'b01) : 2'b00;
  assign bus.csr_addr  = grant ? win_addr  : '0;
  assign bus.csr_wdata = grant ? win_wdata : '0;
  assign bus.csr_wen   = grant &  win_we & in_range;
  assign bus.csr_ren   = grant & ~win_we & in_range;
  assign bus.rsp_valid = (state_q == RESP && !rst) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  assign busy         = (state_q != IDLE);
  assign owner        = owner_q;
  assign locked       = locked_q;
  assign lock_timeout = lock_timeout_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      prio_q         <= 1'b0;
      owner_q        <= 1'b0;
      locked_q       <= 1'b0;
      idle_cnt_q     <= '0;
      rsp_rdata_q    <= '0;
      rsp_err_q      <= 1'b0;
      lock_timeout_q <= 1'b0;
    end else begin
      lock_timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            rsp_rdata_q <= (in_range && !win_we) ? bus.csr_rdata : '0;
            rsp_err_q   <= !in_range;
            owner_q     <= winner;
            locked_q    <= win_lock;
            // Fairness only rotates between unlocked transactions.
            if (!locked_q && !win_lock)
              prio_q <= ~winner;
            idle_cnt_q  <= '0;
            state_q     <= RESP;
          end else if (locked_q && !bus.req_valid[owner_q]) begin
            if (idle_cnt_q == CNT_LAST) begin
              locked_q       <= 1'b0;
              lock_timeout_q <= 1'b1;
              idle_cnt_q     <= '0;
            end else begin
              idle_cnt_q <= idle_cnt_q + CNT_W'(1);
            end
          end
        end
        RESP: begin
          if (bus.rsp_ready[owner_q])
            state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_csr_arbiter.sv
// Directed spec scenarios followed by randomized traffic, all checked
// against a transaction-level reference model of the arbiter.
module tb_csr_arbiter;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 64;
  localparam logic [7:0] LIMIT = 8'h80;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  csr_arbiter_if #(.AW(AW), .DW(DW)) bus();
  logic busy, owner, locked, lock_timeout;

  csr_arbiter #(
    .CSR_ADDR_WIDTH(AW), .CSR_DATA_WIDTH(DW), .CSR_LIMIT(LIMIT), .LOCK_TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus),
    .busy(busy), .owner(owner), .locked(locked), .lock_timeout(lock_timeout)
  );

  // Requester drive
  logic [1:0]  rv, rwe, rlock, rrdy;
  logic [7:0]  raddr [2];
  logic [31:0] rwd   [2];
  assign bus.req_valid = rv;
  assign bus.req_we    = rwe;
  assign bus.req_lock  = rlock;
  assign bus.req_addr  = {raddr[1], raddr[0]};
  assign bus.req_wdata = {rwd[1], rwd[0]};
  assign bus.rsp_ready = rrdy;

  function automatic logic [31:0] init_val(input logic [7:0] a);
    return (a == 8'h10) ? 32'hDEADBEEF : {a, ~a, a ^ 8'h5A, 8'hC3};
  endfunction

  // CSR file seen by the DUT
  bit [31:0] mem    [256];
  bit        mem_wr [256];
  assign bus.csr_rdata = mem_wr[bus.csr_addr] ? mem[bus.csr_addr] : init_val(bus.csr_addr);
  always @(posedge clk) begin
    if (bus.csr_wen) begin
      mem[bus.csr_addr]    <= bus.csr_wdata;
      mem_wr[bus.csr_addr] <= 1'b1;
    end
  end

  // Reference model
  bit [31:0]   sh    [256];
  bit          sh_wr [256];
  bit          m_busy, m_owner, m_locked, m_prio, m_to, m_err;
  int          m_idle;
  logic [31:0] m_rdata;
  int          e_win = -1;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [31:0] exp_rd(input logic [7:0] a);
    return sh_wr[a] ? sh[a] : init_val(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Mid-cycle: predict this cycle's outputs from model state and inputs.
  task automatic settle();
    bit el0, el1, inr, e_we;
    logic [1:0]  e_ready;
    logic [7:0]  e_addr;
    logic [31:0] e_wd;
    #4;
    e_win = -1;
    if (!rst && !m_busy) begin
      el0 = rv[0] && (!m_locked || m_owner == 1'b0);
      el1 = rv[1] && (!m_locked || m_owner == 1'b1);
      if (el0 && el1) e_win = int'(m_prio);
      else if (el0)   e_win = 0;
      else if (el1)   e_win = 1;
    end
    e_ready = 2'b00; e_addr = 8'h00; e_wd = 32'h0; inr = 1'b0; e_we = 1'b0;
    if (e_win >= 0) begin
      e_ready[e_win] = 1'b1;
      e_addr = raddr[e_win];
      e_wd   = rwd[e_win];
      e_we   = rwe[e_win];
      inr    = e_addr < LIMIT;
    end
    chk("req_ready", bus.req_ready, e_ready);
    chk("csr_wen", bus.csr_wen, (e_win >= 0) && e_we && inr);
    chk("csr_ren", bus.csr_ren, (e_win >= 0) && !e_we && inr);
    chk("csr_addr", bus.csr_addr, e_addr);
    chk("csr_wdata", bus.csr_wdata, e_wd);
    chk("rsp_valid", bus.rsp_valid, (!rst && m_busy) ? (m_owner ? 2'b10 : 2'b01) : 2'b00);
    chk("rsp_rdata", bus.rsp_rdata, m_rdata);
    chk("rsp_err", bus.rsp_err, m_err);
    chk("busy", busy, m_busy);
    chk("owner", owner, m_owner);
    chk("locked", locked, m_locked);
    chk("lock_timeout", lock_timeout, m_to);
  endtask

  // Clock edge: advance the model by one transaction step.
  task automatic tick();
    logic [7:0] a;
    @(posedge clk);
    m_to = 1'b0;
    if (rst) begin
      m_busy = 0; m_prio = 0; m_owner = 0; m_locked = 0; m_idle = 0; m_rdata = '0; m_err = 0;
    end else if (e_win >= 0) begin
      a = raddr[e_win];
      $display("txn t=%0t req=%0d %s addr=%02h data=%08h lock=%0d", $time, e_win,
               rwe[e_win] ? "wr" : "rd", a, rwd[e_win], rlock[e_win]);
      m_err   = !(a < LIMIT);
      m_rdata = (!m_err && !rwe[e_win]) ? exp_rd(a) : 32'h0;
      if (!m_err && rwe[e_win]) begin
        sh[a] = rwd[e_win];
        sh_wr[a] = 1'b1;
      end
      if (!m_locked && !rlock[e_win]) m_prio = (e_win == 0);
      m_owner  = (e_win == 1);
      m_locked = rlock[e_win];
      m_idle   = 0;
      m_busy   = 1;
    end else if (m_busy) begin
      if (rrdy[m_owner]) m_busy = 0;
    end else if (m_locked && !rv[m_owner]) begin
      m_idle++;
      if (m_idle == TO) begin
        m_locked = 0; m_to = 1; m_idle = 0;
      end
    end
    #1;
  endtask

  task automatic cyc();
    settle();
    tick();
  endtask

  task automatic set_req(input int i, input bit we, input bit lk, input logic [7:0] a, input logic [31:0] d);
    rv[i] = 1'b1; rwe[i] = we; rlock[i] = lk; raddr[i] = a; rwd[i] = d;
  endtask

  task automatic new_req(input int i);
    logic [7:0] a;
    case ($urandom_range(0, 5))
      0:       a = 8'h7F;
      1:       a = 8'h80;
      2:       a = 8'($urandom_range(128, 255));
      default: a = 8'($urandom_range(0, 127));
    endcase
    set_req(i, 1'($urandom_range(0, 1)), ($urandom_range(0, 5) == 0), a, $urandom);
  endtask

  initial begin
    logic [31:0] want;
    int cnt;
    bit seen;
    rst = 1'b1; rv = 2'b11; rwe = 2'b11; rlock = 2'b00; rrdy = 2'b11;
    raddr[0] = 8'h04; raddr[1] = 8'h08; rwd[0] = 32'h1; rwd[1] = 32'h2;
    @(posedge clk); #1;
    tick();
    // Reset held with requests pending: nothing may be granted.
    settle();
    chk("rst_ready", bus.req_ready, 2'b00);
    chk("rst_wen", bus.csr_wen, 1'b0);
    chk("rst_rsp_valid", bus.rsp_valid, 2'b00);
    tick();
    rst = 1'b0; rv = 2'b00;
    settle();
    chk("rst_busy", busy, 1'b0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_rdata", bus.rsp_rdata, 32'h0);
    tick();

    // Continuous writes from both: alternate grants every 2 cycles.
    set_req(0, 1, 0, 8'h20, $urandom);
    set_req(1, 1, 0, 8'h24, $urandom);
    for (int k = 0; k < 8; k++) begin
      settle();
      chk("r28_ready", bus.req_ready, (k % 2) ? 2'b00 : (((k / 2) % 2) ? 2'b10 : 2'b01));
      chk("r28_wen", bus.csr_wen, (k % 2) ? 1'b0 : 1'b1);
      tick();
      if (e_win >= 0) begin
        raddr[e_win] = 8'($urandom_range(32, 127));
        rwd[e_win]   = $urandom;
      end
    end
    rv = 2'b00;
    cyc();

    // Host read of 0x10.
    set_req(0, 0, 0, 8'h10, 32'h0);
    settle();
    chk("r27_ready", bus.req_ready, 2'b01);
    chk("r27_ren", bus.csr_ren, 1'b1);
    chk("r27_addr", bus.csr_addr, 8'h10);
    tick();
    rv = 2'b00;
    settle();
    chk("r27_rsp_valid", bus.rsp_valid, 2'b01);
    chk("r27_rdata", bus.rsp_rdata, 32'hDEADBEEF);
    chk("r27_err", bus.rsp_err, 1'b0);
    tick();

    // Out-of-range sequencer write.
    set_req(1, 1, 0, 8'h90, 32'hCAFE0001);
    settle();
    chk("r29_ready", bus.req_ready, 2'b10);
    chk("r29_wen", bus.csr_wen, 1'b0);
    tick();
    rv = 2'b00;
    settle();
    chk("r29_err", bus.rsp_err, 1'b1);
    chk("r29_rdata", bus.rsp_rdata, 32'h0);
    tick();

    // Response back-pressure for 5 cycles with the sequencer waiting.
    want = exp_rd(8'h20);
    rrdy = 2'b00;
    set_req(0, 0, 0, 8'h20, 32'h0);
    cyc();
    rv[0] = 1'b0;
    set_req(1, 1, 0, 8'h30, 32'h12345678);
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("r31_rsp_valid", bus.rsp_valid, 2'b01);
      chk("r31_rdata", bus.rsp_rdata, want);
      chk("r31_strobes", {bus.csr_wen, bus.csr_ren}, 2'b00);
      tick();
    end
    rrdy = 2'b11;
    cyc();
    settle();
    chk("r31_next_grant", bus.req_ready, 2'b10);
    tick();
    rv = 2'b00;
    cyc();

    // Lock released by an unlocking transaction from the owner.
    set_req(1, 1, 1, 8'h40, $urandom);
    cyc();
    rv[1] = 1'b0;
    set_req(0, 0, 0, 8'h44, 32'h0);
    cyc();
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("r30_hold", bus.req_ready, 2'b00);
      tick();
    end
    set_req(1, 1, 0, 8'h48, $urandom);
    settle();
    chk("r30_owner_grant", bus.req_ready, 2'b10);
    tick();
    rv[1] = 1'b0;
    cyc();
    settle();
    chk("r30_host_grant", bus.req_ready, 2'b01);
    chk("r30_unlocked", locked, 1'b0);
    tick();
    rv[0] = 1'b0;
    cyc();

    // Lock released by idle timeout.
    set_req(1, 1, 1, 8'h40, $urandom);
    cyc();
    rv[1] = 1'b0;
    set_req(0, 0, 0, 8'h44, 32'h0);
    cnt = 0;
    seen = 1'b0;
    for (int k = 0; k < 200; k++) begin
      settle();
      if (lock_timeout) begin
        seen = 1'b1;
        chk("r30_to_locked", locked, 1'b0);
        chk("r30_to_ready", bus.req_ready, 2'b01);
        break;
      end
      if (!busy && locked) cnt++;
      tick();
    end
    chk("r30_to_seen", seen, 1'b1);
    chk("r30_idle_cycles", cnt, TO);
    tick();
    rv[0] = 1'b0;
    cyc();

    // Reset during RESP abandons the response and clears prio.
    set_req(0, 0, 1, 8'h50, 32'h0);
    cyc();
    rv = 2'b00;
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    settle();
    chk("r32_busy", busy, 1'b0);
    chk("r32_rsp_valid", bus.rsp_valid, 2'b00);
    chk("r32_locked", locked, 1'b0);
    tick();
    set_req(0, 0, 0, 8'h54, 32'h0);
    set_req(1, 1, 0, 8'h60, $urandom);
    settle();
    chk("r32_prio", bus.req_ready, 2'b01);
    tick();
    rv[0] = 1'b0;

    // Randomized traffic obeying the hold-until-ready protocol.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 2; i++)
        if (!rv[i] && $urandom_range(0, 2) == 0) new_req(i);
      rrdy = 2'($urandom_range(0, 3));
      rst  = ($urandom_range(0, 299) == 0);
      settle();
      tick();
      if (e_win >= 0) rv[e_win] = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/csr_arbiter.md
CSR_ARBITER -- requirements
Module: csr_arbiter

Interface
REQ-001 SHALL have parameter CSR_ADDR_WIDTH, default 8, meaning the CSR byte-address width.
REQ-002 SHALL have parameter CSR_DATA_WIDTH, default 32, meaning the CSR data width.
REQ-003 SHALL have parameter CSR_LIMIT, default 8'h80, meaning the first out-of-range address; addresses >= CSR_LIMIT are rejected.
REQ-004 SHALL have parameter LOCK_TIMEOUT, default 64, meaning the number of locked idle cycles before a forced lock release.
REQ-005 SHALL have ports:
 clk  in  1  sole clock, rising edge.
 rst  in  1  synchronous, active-high reset.
 req_valid  in  2  per-requester request valid (bit0 = host AXI path, bit1 = internal sequencer).
 req_ready  out  2  per-requester grant/accept, one-hot.
 req_we  in  2  1 = write, 0 = read.
 req_lock  in  2  hold ownership after this transaction.
 req_addr  in  2*CSR_ADDR_WIDTH  packed addresses; requester i uses slice i.
 req_wdata  in  2*CSR_DATA_WIDTH  packed write data.
 rsp_valid  out  2  per-requester response valid.
 rsp_ready  in  2  per-requester response accept.
 rsp_rdata  out  CSR_DATA_WIDTH  registered read data, shared.
 rsp_err  out  1  registered error flag for the current response.
 csr_wen  out  1  single-cycle write strobe.
 csr_ren  out  1  single-cycle read strobe.
 csr_addr  out  CSR_ADDR_WIDTH  CSR address.
 csr_wdata  out  CSR_DATA_WIDTH  CSR write data.
 csr_rdata  in  CSR_DATA_WIDTH  combinational read data for csr_addr.
 busy  out  1  state != IDLE.
 owner  out  1  index of the last granted requester.
 locked  out  1  lock currently held.
 lock_timeout  out  1  one-cycle pulse on forced lock release.

Function
REQ-006 SHALL implement a two-state FSM, IDLE and RESP.
REQ-007 In IDLE with no eligible req_valid, the block SHALL hold all strobes and req_ready at 0.
REQ-008 Eligible requesters in IDLE SHALL be both requesters when unlocked, and only the current owner when locked.
REQ-009 When unlocked, arbitration SHALL be round-robin: priority pointer prio gives the winner when both request; a single requester always wins.
REQ-010 On grant, in the same cycle, the block SHALL:
 - assert req_ready[winner] combinationally;
 - drive csr_addr and csr_wdata from the winner's slices;
 - assert csr_wen (we=1) or csr_ren (we=0) only when addr < CSR_LIMIT.
REQ-011 On the grant edge, the block SHALL:
 - register rsp_rdata <= csr_rdata for an in-range read, else 0;
 - register rsp_err <= (addr >= CSR_LIMIT);
 - set owner <= winner and locked <= req_lock[winner];
 - advance state to RESP.
REQ-012 The prio pointer SHALL update to ~winner on grant only when unlocked before and after the grant; it SHALL hold otherwise.
REQ-013 An out-of-range access SHALL produce no csr_wen or csr_ren, and SHALL complete with rsp_err=1 and rsp_rdata=0.
REQ-014 In RESP, rsp_valid[owner] SHALL be 1, and rsp_rdata and rsp_err SHALL be stable until rsp_ready[owner]=1.
REQ-015 On that rsp_ready edge, state SHALL return to IDLE; no new grant SHALL occur in the RESP cycle, giving a 2-cycle minimum per transaction.
REQ-016 Request latency SHALL be 0 cycles when an eligible requester arrives in IDLE; response SHALL follow 1 cycle after grant.
REQ-017 While locked in IDLE with req_valid[owner]=0, an idle counter SHALL increment.
REQ-018 The idle counter SHALL clear on any grant, and on entry into RESP.
REQ-019 When the idle counter reaches LOCK_TIMEOUT-1, the block SHALL clear locked, pulse lock_timeout for 1 cycle, and clear the counter.
REQ-020 A locked owner granted with req_lock=0 SHALL release the lock at that grant.
REQ-021 A requester SHALL hold req_valid and its payload stable until req_ready; the arbiter may sample the payload only in the grant cycle.
REQ-022 At most one of csr_wen and csr_ren SHALL be high in any cycle, for at most 1 cycle per grant.
REQ-023 csr_addr and csr_wdata SHALL be 0 when no grant occurs.

Reset
REQ-024 When rst=1 at a clk edge, the block SHALL set state=IDLE, prio=0, owner=0, locked=0, idle counter=0, rsp_rdata=0, rsp_err=0, lock_timeout=0.
REQ-025 During reset, all req_ready, rsp_valid, csr_wen and csr_ren SHALL be 0.
REQ-026 Reset asserted in RESP SHALL abandon the pending response without a rsp_valid handshake.

Verification
REQ-027 Host read 8'h10 with csr_rdata=32'hDEADBEEF -> same cycle: req_ready=2'b01, csr_ren=1, csr_addr=8'h10; next cycle: rsp_valid=2'b01, rsp_rdata=32'hDEADBEEF, rsp_err=0.
REQ-028 Both requesters issue writes continuously with rsp_ready tied high after reset -> grants alternate 0,1,0,1, one grant every 2 cycles, with exactly one csr_wen per grant.
REQ-029 Sequencer write to 8'h90 -> csr_wen stays 0; response gives rsp_err=1 and rsp_rdata=0.
REQ-030 Sequencer writes with req_lock=1, then the host requests -> the host is not granted until the sequencer issues with req_lock=0, or until lock_timeout pulses after 64 idle cycles; locked then reads 0.
REQ-031 rsp_ready held 0 for 5 cycles -> rsp_valid and rsp_rdata remain stable, with no new strobes.
REQ-032 rst=1 in the RESP cycle -> next cycle: busy=0, rsp_valid=0, locked=0, prio=0.
